// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer state
// encoding and mem-stage jump encoding.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_RECOVER  = 2'b10
    } hazard_state_t;

    localparam logic [1:0] JUMP_NONE = 2'b00;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        if (&val)
            return val;
        return val + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-memory wait freezes,
// MEM-stage branch/jump redirects with flushes, and ID load-use bubbles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  ex_memread,
    input  logic [4:0]            ex_rd,
    input  logic                  mem_branch,
    input  logic [1:0]            mem_jump,
    input  logic                  mem_taken,
    input  logic [DATA_WIDTH-1:0] mem_pc_target,
    input  logic [DATA_WIDTH-1:0] mem_pc_plus_4,
    input  logic [DATA_WIDTH-1:0] mem_pc_predict,
    input  logic                  mem_memread,
    input  logic                  mem_memwrite,
    input  logic                  dmem_ready,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_stall,
    output logic                  idex_flush,
    output logic                  exmem_stall,
    output logic                  exmem_flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  mem_timeout,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hazard_state_t         state, state_next;
    logic                  memop, mispredict, load_use, wait_stall;
    logic [DATA_WIDTH-1:0] actual_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  timeout_q;

    assign memop       = mem_memread | mem_memwrite;
    assign actual_next = mem_taken ? mem_pc_target : mem_pc_plus_4;
    assign mispredict  = (mem_branch | (mem_jump != JUMP_NONE)) &
                         (actual_next != mem_pc_predict);
    assign load_use    = ex_memread & (ex_rd != 5'd0) &
                         ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // Outputs are forced quiet while reset is held so nothing downstream moves.
    always_comb begin
        state_next     = state;
        wait_stall     = 1'b0;
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        idex_stall     = 1'b0;
        exmem_stall    = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (memop && !dmem_ready) begin
                        wait_stall = 1'b1;
                        state_next = ST_MEM_WAIT;
                    end else if (mispredict) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = actual_next;
                        ifid_flush     = 1'b1;
                        idex_flush     = 1'b1;
                        exmem_flush    = 1'b1;
                        state_next     = ST_RECOVER;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dmem_ready)
                        wait_stall = 1'b1;
                    else
                        state_next = ST_RUN;
                end
                ST_RECOVER: begin
                    // Stages hold flushed bubbles; only a memory wait matters here.
                    if (memop && !dmem_ready) begin
                        wait_stall = 1'b1;
                        state_next = ST_MEM_WAIT;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
            if (wait_stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end
        end
    end

    // Wait counter parks at MEM_TIMEOUT; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (wait_stall) begin
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_MAX - 1'b1)
                timeout_q <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign mem_timeout = timeout_q & ~reset;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (redirect_valid),
        .count (mispredict_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; 4-bit counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          ex_memread, mem_branch, mem_taken;
    logic [1:0]    mem_jump;
    logic [DW-1:0] mem_pc_target, mem_pc_plus_4, mem_pc_predict;
    logic          mem_memread, mem_memwrite, dmem_ready;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_stall, exmem_flush, redirect_valid, mem_timeout;
    logic [DW-1:0] redirect_pc;
    logic [CW-1:0] mispredict_cnt, stall_cnt;
    logic [7:0]    ctl;

    int total  = 0;
    int passed = 0;

    // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, exmem_flush, redirect_valid}
    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_LU   = 8'hC4;
    localparam logic [7:0] C_MISP = 8'h0F;
    localparam logic [7:0] C_MEM  = 8'hF0;

    assign ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                  ifid_flush, idex_flush, exmem_flush, redirect_valid};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch(mem_branch),
        .mem_jump(mem_jump), .mem_taken(mem_taken), .mem_pc_target(mem_pc_target),
        .mem_pc_plus_4(mem_pc_plus_4), .mem_pc_predict(mem_pc_predict),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
        .exmem_flush(exmem_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mem_timeout(mem_timeout),
        .mispredict_cnt(mispredict_cnt), .stall_cnt(stall_cnt)
    );

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
        mem_branch = 1'b0; mem_jump = 2'b00; mem_taken = 1'b0;
        mem_pc_target = '0; mem_pc_plus_4 = '0; mem_pc_predict = '0;
        mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_memread = 1'b1; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic set_ctrl_flow(input logic br, input logic [1:0] jmp, input logic tk,
                                 input logic [DW-1:0] tgt, input logic [DW-1:0] p4,
                                 input logic [DW-1:0] pred);
        mem_branch = br; mem_jump = jmp; mem_taken = tk;
        mem_pc_target = tgt; mem_pc_plus_4 = p4; mem_pc_predict = pred;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        set_load_use(5'd5, 5'd5, 5'd0);
        mem_memread = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL reset_ctl: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        idle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({mispredict_cnt, stall_cnt, mem_timeout, ctl, redirect_pc} !== '0)
            $display("FAIL reset_state: mcnt=%0d scnt=%0d to=%b ctl=%h rpc=%h want all 0",
                     mispredict_cnt, stall_cnt, mem_timeout, ctl, redirect_pc);
        else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5, 5'd3, 5'd5);
        @(negedge clk);
        total++;
        if (ctl !== C_LU) $display("FAIL lu_rs2: got %h want %h", ctl, C_LU); else passed++;
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL lu_release: got %h want %h", ctl, C_NONE); else passed++;
        total++;
        if (stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else passed++;
        next_cycle();
        set_load_use(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL lu_x0: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        set_load_use(5'd7, 5'd7, 5'd2);
        @(negedge clk);
        total++;
        if (ctl !== C_LU) $display("FAIL lu_rs1: got %h want %h", ctl, C_LU); else passed++;
        next_cycle();
        set_load_use(5'd7, 5'd6, 5'd2);
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL lu_nomatch: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        set_ctrl_flow(1'b1, 2'b00, 1'b1, 32'h100, 32'h48, 32'h44);
        @(negedge clk);
        total++;
        if (ctl !== C_MISP || redirect_pc !== 32'h100)
            $display("FAIL misp_taken: ctl=%h pc=%h want %h pc=100", ctl, redirect_pc, C_MISP);
        else passed++;
        total++;
        if (mispredict_cnt !== 4'd0) $display("FAIL misp_cnt0: got %0d want 0", mispredict_cnt); else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL misp_recover: got %h want %h", ctl, C_NONE); else passed++;
        total++;
        if (mispredict_cnt !== 4'd1) $display("FAIL misp_cnt1: got %0d want 1", mispredict_cnt); else passed++;
        next_cycle();
        set_ctrl_flow(1'b0, 2'b01, 1'b1, 32'h200, 32'h48, 32'h200);
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL jump_correct: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        set_ctrl_flow(1'b0, 2'b11, 1'b1, 32'h200, 32'h48, 32'h80);
        @(negedge clk);
        total++;
        if (ctl !== C_MISP || redirect_pc !== 32'h200)
            $display("FAIL jump_misp: ctl=%h pc=%h want %h pc=200", ctl, redirect_pc, C_MISP);
        else passed++;
        next_cycle();
        idle();
        next_cycle();
        set_ctrl_flow(1'b1, 2'b00, 1'b0, 32'h100, 32'h48, 32'h100);
        @(negedge clk);
        total++;
        if (ctl !== C_MISP || redirect_pc !== 32'h48)
            $display("FAIL misp_nottaken: ctl=%h pc=%h want %h pc=48", ctl, redirect_pc, C_MISP);
        else passed++;
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (mispredict_cnt !== 4'd3) $display("FAIL misp_cnt3: got %0d want 3", mispredict_cnt); else passed++;
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_memwrite = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL mem_ready_hit: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        mem_memwrite = 1'b0; mem_memread = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (ctl !== C_MEM) $display("FAIL mem_wait_c%0d: got %h want %h", k, ctl, C_MEM); else passed++;
            next_cycle();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL mem_release: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (stall_cnt !== 4'd3 || mem_timeout !== 1'b0)
            $display("FAIL mem_cnt: scnt=%0d to=%b want 3 0", stall_cnt, mem_timeout);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_memread = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (ctl !== C_MEM || mem_timeout !== (k >= 5))
                $display("FAIL timeout_c%0d: ctl=%h to=%b want %h to=%b", k, ctl, mem_timeout, C_MEM, (k >= 5));
            else passed++;
            next_cycle();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_NONE || mem_timeout !== 1'b1)
            $display("FAIL timeout_release: ctl=%h to=%b want %h to=1", ctl, mem_timeout, C_NONE);
        else passed++;
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (mem_timeout !== 1'b1 || stall_cnt !== 4'd10)
            $display("FAIL timeout_sticky: to=%b scnt=%0d want 1 10", mem_timeout, stall_cnt);
        else passed++;
        do_reset();
        @(negedge clk);
        total++;
        if (mem_timeout !== 1'b0) $display("FAIL timeout_clear: got %b want 0", mem_timeout); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        set_load_use(5'd5, 5'd0, 5'd5);
        set_ctrl_flow(1'b1, 2'b00, 1'b1, 32'h100, 32'h48, 32'h44);
        @(negedge clk);
        total++;
        if (ctl !== C_MISP) $display("FAIL prio_misp_over_lu: got %h want %h", ctl, C_MISP); else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL prio_recover_ignores: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        set_ctrl_flow(1'b0, 2'b00, 1'b0, '0, '0, '0);
        @(negedge clk);
        total++;
        if (ctl !== C_LU) $display("FAIL prio_lu_after: got %h want %h", ctl, C_LU); else passed++;
        next_cycle();
        idle();
        set_ctrl_flow(1'b1, 2'b00, 1'b0, 32'h100, 32'h48, 32'h48);
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL prio_correct_pred: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        set_ctrl_flow(1'b1, 2'b00, 1'b1, 32'h100, 32'h48, 32'h44);
        set_load_use(5'd5, 5'd5, 5'd0);
        mem_memread = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_MEM) $display("FAIL prio_mem_over_misp: got %h want %h", ctl, C_MEM); else passed++;
        next_cycle();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_memread = 1'b1; dmem_ready = 1'b0;
        next_cycle();
        next_cycle();
        idle();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_NONE) $display("FAIL rst_wait_during: got %h want %h", ctl, C_NONE); else passed++;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_NONE || stall_cnt !== 4'd0 || mem_timeout !== 1'b0)
            $display("FAIL rst_wait_after: ctl=%h scnt=%0d to=%b want 00 0 0", ctl, stall_cnt, mem_timeout);
        else passed++;
        set_load_use(5'd4, 5'd4, 5'd0);
        @(negedge clk);
        total++;
        if (ctl !== C_LU) $display("FAIL rst_wait_run: got %h want %h", ctl, C_LU); else passed++;
        next_cycle();
        idle();
        set_ctrl_flow(1'b1, 2'b00, 1'b1, 32'h100, 32'h48, 32'h44);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_MISP || mispredict_cnt !== 4'd0)
            $display("FAIL rst_recover: ctl=%h mcnt=%0d want %h 0", ctl, mispredict_cnt, C_MISP);
        else passed++;
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_saturate();
        do_reset();
        mem_memread = 1'b1; dmem_ready = 1'b0;
        repeat (20) next_cycle();
        dmem_ready = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (stall_cnt !== 4'hF) $display("FAIL stall_saturate: got %0d want 15", stall_cnt); else passed++;
        total++;
        if (mem_timeout !== 1'b1) $display("FAIL sat_timeout: got %b want 1", mem_timeout); else passed++;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
